// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package muldiv_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  // Bit 1 of the opcode selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute-stage controller and the muldiv unit.
interface muldiv_unit_if #(
  parameter int WIDTH = muldiv_unit_pkg::DEFAULT_WIDTH
);
  import muldiv_unit_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             hiWe;
  logic             loWe;
  logic [WIDTH-1:0] writeData;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand1, operand2, hiWe, loWe, writeData,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, operand1, operand2, hiWe, loWe, writeData,
    output busy, done, divByZero, hi, lo
  );

endinterface

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on the way in,
// result negation on the way out.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a_raw,
  input  logic [WIDTH-1:0]   b_raw,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag,
  output logic               a_neg,
  output logic               b_neg,
  input  logic               is_div,
  input  logic               neg_a,
  input  logic               neg_b,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo
);

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_raw;
  logic [WIDTH-1:0]   rem_raw;

  // Magnitude conversion; unsigned ops pass operands through untouched.
  always_comb begin
    a_neg = is_signed & a_raw[WIDTH-1];
    b_neg = is_signed & b_raw[WIDTH-1];
    a_mag = a_neg ? -a_raw : a_raw;
    b_mag = b_neg ? -b_raw : b_raw;
  end

  // Product negated as a whole; quotient takes the XOR sign, remainder the dividend sign.
  always_comb begin
    prod_fixed = (neg_a ^ neg_b) ? -raw : raw;
    quot_raw   = raw[WIDTH-1:0];
    rem_raw    = raw[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_lo = (neg_a ^ neg_b) ? -quot_raw : quot_raw;
      res_hi = neg_a ? -rem_raw : rem_raw;
    end else begin
      res_hi = prod_fixed[2*WIDTH-1:WIDTH];
      res_lo = prod_fixed[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  op_e                op_reg;
  logic [WIDTH-1:0]   dvs_reg;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_reg;    // {partial hi, multiplier} or {remainder, quotient}
  logic               neg_a_reg;
  logic               neg_b_reg;
  logic               zdiv_reg;
  logic [WIDTH-1:0]   orig_reg;   // untouched operand1, returned in HI on divide by zero
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               dbz_reg;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   res_hi, res_lo;

  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_acc;

  logic               start_acc;
  logic               last_step;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .is_signed (op_is_signed(bus.op)),
    .a_raw     (bus.operand1),
    .b_raw     (bus.operand2),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .is_div    (op_is_div(op_reg)),
    .neg_a     (neg_a_reg),
    .neg_b     (neg_b_reg),
    .raw       (acc_reg),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  assign start_acc = (state_reg == ST_IDLE) && bus.start;
  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

  // One shift-add step (multiply) and one restoring step (divide), selected by op.
  always_comb begin
    mul_addend = acc_reg[0] ? dvs_reg : {WIDTH{1'b0}};
    mul_sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_acc    = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift  = {acc_reg, 1'b0};
    div_diff   = div_shift[2*WIDTH:WIDTH] - {1'b0, dvs_reg};
    div_ok     = ~div_diff[WIDTH];
    div_acc    = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[2*WIDTH-1:WIDTH]),
                  acc_reg[WIDTH-2:0], div_ok};
  end

  // Next-state logic: IDLE -> CALC on start, CALC for WIDTH steps, FINISH for one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.start) state_next = ST_CALC;
      ST_CALC:   if (last_step) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Datapath and architectural HI/LO; HI/LO move only on MTHI/MTLO in IDLE or at FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      op_reg    <= OP_MULT;
      dvs_reg   <= '0;
      acc_reg   <= '0;
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      zdiv_reg  <= 1'b0;
      orig_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.hiWe) hi_reg <= bus.writeData;
          if (bus.loWe) lo_reg <= bus.writeData;
          if (start_acc) begin
            op_reg    <= bus.op;
            neg_a_reg <= a_neg;
            neg_b_reg <= b_neg;
            orig_reg  <= bus.operand1;
            zdiv_reg  <= op_is_div(bus.op) && (bus.operand2 == '0);
            cnt_reg   <= '0;
            if (op_is_div(bus.op)) begin
              dvs_reg <= b_mag;
              acc_reg <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              dvs_reg <= a_mag;
              acc_reg <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        ST_CALC: begin
          acc_reg <= op_is_div(op_reg) ? div_acc : mul_acc;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        ST_FINISH: begin
          hi_reg   <= zdiv_reg ? orig_reg : res_hi;
          lo_reg   <= zdiv_reg ? {WIDTH{1'b1}} : res_lo;
          done_reg <= 1'b1;
          dbz_reg  <= zdiv_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = done_reg;
  assign bus.divByZero = dbz_reg;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a monitor pops on done.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          start_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last_hi = 0;
  logic [31:0] last_lo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic exp_t model(op_e op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint sa, sbv, p, q, r;
    logic [63:0] up;
    e.dbz = 1'b0;
    e.start_cyc = 0;
    e.name = "";
    case (op)
      OP_MULT: begin
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        p = sa * sbv;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else begin
          sa = longint'($signed(a));
          sbv = longint'($signed(b));
          q = sa / sbv;
          r = sa % sbv;
          e.hi = r[31:0];
          e.lo = q[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else begin
          e.hi = a % b;
          e.lo = a / b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no operation outstanding");
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, bus.hi, e.hi);
          check({e.name, "_lo"}, bus.lo, e.lo);
          check({e.name, "_dbz"}, {31'b0, bus.divByZero}, {31'b0, e.dbz});
          check({e.name, "_latency"}, cyc - e.start_cyc, LAT);
          $display("txn %s: hi=%h lo=%h dbz=%0b cycles=%0d", e.name, bus.hi, bus.lo,
                   bus.divByZero, cyc - e.start_cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 60 cycles");
    end
  endtask

  // Issue one operation; returns right after the accepting edge.
  task automatic issue(op_e op, logic [31:0] a, logic [31:0] b, string name, bit push);
    exp_t e;
    @(negedge clk);
    check({name, "_busy_pre"}, {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    bus.op = op;
    bus.operand1 = a;
    bus.operand2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = op_e'($urandom_range(0, 3));
    bus.operand1 = $urandom;
    bus.operand2 = $urandom;
    check({name, "_busy_rise"}, {31'b0, bus.busy}, 32'd1);
    if (push) begin
      e = model(op, a, b);
      e.start_cyc = cyc;
      e.name = name;
      sb.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  task automatic do_op(op_e op, logic [31:0] a, logic [31:0] b, string name);
    issue(op, a, b, name, 1'b1);
    wait_idle();
  endtask

  task automatic mt_write(bit to_hi, logic [31:0] d, string name);
    @(negedge clk);
    bus.hiWe = to_hi;
    bus.loWe = !to_hi;
    bus.writeData = d;
    @(posedge clk); #1;
    bus.hiWe = 1'b0;
    bus.loWe = 1'b0;
    bus.writeData = $urandom;
    if (to_hi) begin
      check({name, "_hi"}, bus.hi, d);
      check({name, "_lo_keep"}, bus.lo, last_lo);
      last_hi = d;
    end else begin
      check({name, "_lo"}, bus.lo, d);
      check({name, "_hi_keep"}, bus.hi, last_hi);
      last_lo = d;
    end
    $display("txn %s: hi=%h lo=%h", name, bus.hi, bus.lo);
  endtask

  initial begin
    logic [31:0] a, b;
    op_e op;
    bus.start = 1'b0;
    bus.op = OP_MULT;
    bus.operand1 = '0;
    bus.operand2 = '0;
    bus.hiWe = 1'b0;
    bus.loWe = 1'b0;
    bus.writeData = '0;

    #12;
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_dbz", {31'b0, bus.divByZero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,          "mult_neg3x7");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,          "div_neg7by2");
    do_op(OP_DIVU,  32'd100,       32'd7,          "divu_100by7");
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  "div_min_by_m1");
    do_op(OP_DIVU,  32'h1234_5678, 32'd0,          "divu_by0");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,          "div_neg_by0");
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000,  "mult_min_sq");
    do_op(OP_DIV,   32'd7,         32'hFFFF_FFFE,  "div_7_by_m2");

    // Interference: second start and MTHI during CALC are both ignored.
    begin
      logic [31:0] hold_hi, hold_lo;
      hold_hi = last_hi;
      hold_lo = last_lo;
      issue(OP_MULTU, 32'd5, 32'd6, "multu_5x6", 1'b1);
      repeat (9) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op = OP_DIVU;
      bus.hiWe = 1'b1;
      bus.writeData = 32'h0000_DEAD;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.hiWe = 1'b0;
      check("busy_hi_hold", bus.hi, hold_hi);
      check("busy_lo_hold", bus.lo, hold_lo);
      check("busy_mid", {31'b0, bus.busy}, 32'd1);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("no_queued_start", {31'b0, bus.busy}, 32'd0);
    end

    mt_write(1'b0, 32'h0000_ABCD, "mtlo_abcd");

    // Reset in the middle of a divide: no result, everything back to zero at once.
    issue(OP_DIVU, 32'hCAFE_F00D, 32'd3, "divu_aborted", 1'b0);
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    $display("txn reset_abort: hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
    last_hi = 0;
    last_lo = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_still_idle", {31'b0, bus.busy}, 32'd0);
    check("abort_lo_kept", bus.lo, 32'd0);

    // Randomised operations with occasional MTHI/MTLO between them.
    for (int i = 0; i < 40; i++) begin
      op = op_e'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      do_op(op, a, b, $sformatf("rand%0d_op%0d", i, int'(op)));
      if ($urandom_range(0, 3) == 0)
        mt_write($urandom_range(0, 1) == 1, $urandom, $sformatf("rand%0d_mt", i));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
